// File: rtl/fp16_pkg.sv
// rtl/fp16_pkg.sv - shared half-precision datapath constants and normaliser state encoding
package fp16_pkg;

    localparam int MANT_W  = 11;
    localparam int EXP_W   = 5;
    localparam int SHCNT_W = 4;

    localparam logic [4:0] EXP_INF      = 5'd31;
    localparam logic [4:0] EXP_MIN_NORM = 5'd1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } norm_state_e;

endpackage

// File: rtl/fp16_mant_normalizer.sv
// rtl/fp16_mant_normalizer.sv - iterative post-add mantissa normaliser with valid/ready on both sides
module fp16_mant_normalizer #(
    parameter int MANT_W  = fp16_pkg::MANT_W,
    parameter int EXP_W   = fp16_pkg::EXP_W,
    parameter int SHCNT_W = fp16_pkg::SHCNT_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MANT_W:0]     in_mant,
    input  logic [EXP_W-1:0]    in_exp,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [MANT_W-1:0]   out_mant,
    output logic [EXP_W-1:0]    out_exp,
    output logic [SHCNT_W-1:0]  out_shift,
    output logic                out_ovf,
    output logic                out_unf
);
    import fp16_pkg::*;

    localparam logic [EXP_W-1:0] EXP_INF_W = EXP_W'(EXP_INF);
    localparam logic [EXP_W-1:0] EXP_MIN_W = EXP_W'(EXP_MIN_NORM);

    norm_state_e          state_q, state_d;
    logic [MANT_W:0]      mant_q, mant_d;
    logic [EXP_W-1:0]     exp_q, exp_d;
    logic [SHCNT_W-1:0]   shift_q, shift_d;
    logic                 ovf_q, ovf_d;
    logic                 unf_q, unf_d;
    logic                 norm_done;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (in_valid)  state_d = ST_NORM;
            ST_NORM: if (norm_done) state_d = ST_DONE;
            ST_DONE: if (out_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = rst_n && (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
    end

    // One normalisation step per NORM cycle; only the plain left shift keeps the FSM in NORM.
    always_comb begin
        mant_d    = mant_q;
        exp_d     = exp_q;
        shift_d   = shift_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        norm_done = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    mant_d  = in_mant;
                    exp_d   = in_exp;
                    shift_d = '0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
            end
            ST_NORM: begin
                norm_done = 1'b1;
                if (exp_q == EXP_INF_W) begin
                    exp_d = exp_q;
                end else if (exp_q == '0) begin
                    exp_d = mant_q[MANT_W-1] ? EXP_MIN_W : '0;
                end else if (mant_q[MANT_W]) begin
                    mant_d = mant_q >> 1;
                    exp_d  = exp_q + EXP_W'(1);
                    if (exp_d == EXP_INF_W) begin
                        mant_d = '0;
                        ovf_d  = 1'b1;
                    end
                end else if (mant_q == '0) begin
                    exp_d = '0;
                end else if (mant_q[MANT_W-1]) begin
                    exp_d = exp_q;
                end else if (exp_q == EXP_MIN_W) begin
                    exp_d = '0;
                    unf_d = 1'b1;
                end else begin
                    mant_d    = mant_q << 1;
                    exp_d     = exp_q - EXP_W'(1);
                    shift_d   = shift_q + SHCNT_W'(1);
                    norm_done = 1'b0;
                end
            end
            default: begin
                mant_d = mant_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mant_q  <= '0;
            exp_q   <= '0;
            shift_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            mant_q  <= mant_d;
            exp_q   <= exp_d;
            shift_q <= shift_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign out_mant  = mant_q[MANT_W-1:0];
    assign out_exp   = exp_q;
    assign out_shift = shift_q;
    assign out_ovf   = ovf_q;
    assign out_unf   = unf_q;

endmodule

// File: tb/tb_fp16_mant_normalizer.sv
// tb/tb_fp16_mant_normalizer.sv - self-checking bench for fp16_mant_normalizer
module tb_fp16_mant_normalizer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] in_mant;
    logic [4:0]  in_exp;
    logic        out_valid;
    logic        out_ready;
    logic [10:0] out_mant;
    logic [4:0]  out_exp;
    logic [3:0]  out_shift;
    logic        out_ovf;
    logic        out_unf;

    int n_checks = 0;
    int n_fail   = 0;

    fp16_mant_normalizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_mant   (in_mant),
        .in_exp    (in_exp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_mant  (out_mant),
        .out_exp   (out_exp),
        .out_shift (out_shift),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] mant;
        logic [4:0]  exp;
        logic [10:0] e_mant;
        logic [4:0]  e_exp;
        logic [3:0]  e_sh;
        logic        e_ovf;
        logic        e_unf;
        int          e_lat;
        int          hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Spec rules applied to plain integers: a value-level view, not a per-cycle one.
    function automatic void ref_model(input int m_in, input int e_in,
                                      output logic [10:0] om, output logic [4:0] oe,
                                      output logic [3:0] osh, output logic oovf,
                                      output logic ounf, output int lat);
        int m = m_in, e = e_in, sh = 0;
        oovf = 1'b0;
        ounf = 1'b0;
        if (e == 31) begin
        end else if (e == 0) begin
            e = ((m / 1024) % 2 == 1) ? 1 : 0;
        end else if (m >= 2048) begin
            m = m / 2;
            e = e + 1;
            if (e == 31) begin m = 0; oovf = 1'b1; end
        end else if (m == 0) begin
            e = 0;
        end else begin
            while (m < 1024 && e > 1) begin m = m * 2; e = e - 1; sh = sh + 1; end
            if (m < 1024) begin e = 0; ounf = 1'b1; end
        end
        om  = 11'(m % 2048);
        oe  = 5'(e);
        osh = 4'(sh);
        lat = sh + 1;
    endfunction

    task automatic do_txn(input string tag, input logic [11:0] m, input logic [4:0] e, input int hold,
                          output logic [10:0] om, output logic [4:0] oe, output logic [3:0] osh,
                          output logic oovf, output logic ounf, output int lat);
        int t = 0;
        @(negedge clk);
        while (!in_ready && t < 50) begin @(negedge clk); t++; end
        if (t >= 50) check({tag, " in_ready timeout"}, 32'(in_ready), 32'd1);
        in_mant  = m;
        in_exp   = e;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
        if (!out_valid) check({tag, " out_valid timeout"}, 32'(out_valid), 32'd1);
        om = out_mant; oe = out_exp; osh = out_shift; oovf = out_ovf; ounf = out_unf;
        check({tag, " in_ready in DONE"}, 32'(in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({tag, " hold out_valid"}, 32'(out_valid), 32'd1);
            check({tag, " hold in_ready"}, 32'(in_ready), 32'd0);
            check({tag, " hold stable"}, {out_mant, out_exp, out_shift, out_ovf, out_unf},
                  {om, oe, osh, oovf, ounf});
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        check({tag, " out_valid after handshake"}, 32'(out_valid), 32'd0);
        check({tag, " in_ready after handshake"}, 32'(in_ready), 32'd1);
    endtask

    vec_t vecs[$];

    initial begin
        logic [10:0] om;
        logic [4:0]  oe;
        logic [3:0]  osh;
        logic        oovf, ounf;
        int          lat;
        logic [10:0] rm;
        logic [4:0]  re;
        logic [3:0]  rsh;
        logic        rovf, runf;
        int          rlat;

        vecs.push_back('{12'h400, 5'd15, 11'h400, 5'd15, 4'd0,  1'b0, 1'b0, 1,  0});
        vecs.push_back('{12'hC01, 5'd15, 11'h600, 5'd16, 4'd0,  1'b0, 1'b0, 1,  0});
        vecs.push_back('{12'h003, 5'd20, 11'h600, 5'd11, 4'd9,  1'b0, 1'b0, 10, 5});
        vecs.push_back('{12'h010, 5'd3,  11'h040, 5'd0,  4'd2,  1'b0, 1'b1, 3,  0});
        vecs.push_back('{12'h800, 5'd30, 11'h000, 5'd31, 4'd0,  1'b1, 1'b0, 1,  0});
        vecs.push_back('{12'h000, 5'd12, 11'h000, 5'd0,  4'd0,  1'b0, 1'b0, 1,  0});
        vecs.push_back('{12'h123, 5'd31, 11'h123, 5'd31, 4'd0,  1'b0, 1'b0, 1,  0});
        vecs.push_back('{12'h455, 5'd0,  11'h455, 5'd1,  4'd0,  1'b0, 1'b0, 1,  0});
        vecs.push_back('{12'h001, 5'd20, 11'h400, 5'd10, 4'd10, 1'b0, 1'b0, 11, 0});
        vecs.push_back('{12'h200, 5'd1,  11'h200, 5'd0,  4'd0,  1'b0, 1'b1, 1,  0});

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_mant = '0; in_exp = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready", 32'(in_ready), 32'd0);
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset outputs", {out_mant, out_exp, out_shift, out_ovf, out_unf}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready after release", 32'(in_ready), 32'd1);

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            do_txn(tag, vecs[i].mant, vecs[i].exp, vecs[i].hold, om, oe, osh, oovf, ounf, lat);
            check({tag, " mant"},  32'(om),   32'(vecs[i].e_mant));
            check({tag, " exp"},   32'(oe),   32'(vecs[i].e_exp));
            check({tag, " shift"}, 32'(osh),  32'(vecs[i].e_sh));
            check({tag, " ovf"},   32'(oovf), 32'(vecs[i].e_ovf));
            check({tag, " unf"},   32'(ounf), 32'(vecs[i].e_unf));
            check({tag, " latency"}, 32'(lat), 32'(vecs[i].e_lat));
        end

        // Reset during NORM of the deep-shift case discards the word.
        @(negedge clk);
        in_mant = 12'h003; in_exp = 5'd20; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("midreset out_valid", 32'(out_valid), 32'd0);
        check("midreset outputs", {out_mant, out_exp, out_shift, out_ovf, out_unf}, 32'd0);
        check("midreset in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        check("midreset in_ready high", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk); #1;
        check("midreset stays idle", 32'(out_valid), 32'd0);

        for (int i = 0; i < 200; i++) begin
            int w;
            logic [11:0] m;
            logic [4:0]  e;
            string tag;
            w = $urandom_range(0, 12);
            m = 12'($urandom & ((32'd1 << w) - 1));
            e = 5'($urandom_range(0, 31));
            tag = $sformatf("rnd%0d m=%0h e=%0d", i, m, e);
            ref_model(int'(m), int'(e), rm, re, rsh, rovf, runf, rlat);
            do_txn(tag, m, e, (i % 17 == 0) ? 2 : 0, om, oe, osh, oovf, ounf, lat);
            check({tag, " result"}, {om, oe, osh, oovf, ounf}, {rm, re, rsh, rovf, runf});
            check({tag, " latency"}, 32'(lat), 32'(rlat));
            if (oovf && ounf) check({tag, " flags exclusive"}, 32'd1, 32'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
